// File: rtl/rsa_ctrl_pkg.sv
// Shared types and constants for the RSA key sequencer and its GCD engine.
package rsa_ctrl_pkg;

    localparam int unsigned RSA_W       = 4;
    localparam int unsigned RSA_DW      = 2 * RSA_W;
    localparam int unsigned RSA_TIMEOUT = 4095;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        CALC   = 4'd2,
        E_INIT = 4'd3,
        GCD    = 4'd4,
        E_CHK  = 4'd5,
        D_INIT = 4'd6,
        D_STEP = 4'd7,
        DONE   = 4'd8,
        ERR    = 4'd9
    } rsa_state_e;

endpackage

// File: rtl/rsa_gcd_iter.sv
// Subtractive Euclid engine: one subtract per cycle, done pulses when operands meet.
module rsa_gcd_iter
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned DW = RSA_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          start,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic          done,
    output logic [DW-1:0] gcd
);

    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    // Operand registers; a_q holds the result once the engine stops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    // Load on start, otherwise subtract the smaller operand from the larger.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (clr) begin
            a_d   = '0;
            b_d   = '0;
            run_d = 1'b0;
        end else if (start) begin
            a_d   = a_in;
            b_d   = b_in;
            run_d = 1'b1;
        end else if (run_q) begin
            if (a_q == b_q) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else if (a_q > b_q) begin
                a_d = a_q - b_q;
            end else begin
                b_d = b_q - a_q;
            end
        end
    end

    assign done = done_q;
    assign gcd  = a_q;

endmodule

// File: rtl/rsa_key_sequencer.sv
// Derives N, phi, e, d from two small primes under a start/busy/done handshake.
module rsa_key_sequencer
    import rsa_ctrl_pkg::*;
#(
    parameter int unsigned W       = RSA_W,
    parameter int unsigned TIMEOUT = RSA_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   p_in,
    input  logic [W-1:0]   q_in,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [2*W-1:0] n_out,
    output logic [2*W-1:0] phi_out,
    output logic [2*W-1:0] e_out,
    output logic [2*W-1:0] d_out
);

    localparam int unsigned DW = 2 * W;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    rsa_state_e    state_q, state_d;
    logic [W-1:0]  p_q, p_d, q_q, q_d;
    logic [DW-1:0] n_q, n_d, phi_q, phi_d;
    logic [DW-1:0] cand_q, cand_d, e_q, e_d;
    logic [DW-1:0] dexp_q, dexp_d, r_q, r_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DW-1:0] n_out_q, n_out_d, phi_out_q, phi_out_d;
    logic [DW-1:0] e_out_q, e_out_d, d_out_q, d_out_d;

    logic          gcd_start_c, gcd_clr_c, gcd_done;
    logic [DW-1:0] gcd_val;
    logic          running_c;
    logic [DW:0]   acc_sum_c;
    logic [DW-1:0] acc_wrap_c;

    rsa_gcd_iter #(.DW(DW)) u_gcd (
        .clk   (clk),
        .reset (reset),
        .clr   (gcd_clr_c),
        .start (gcd_start_c),
        .a_in  (cand_d),
        .b_in  (phi_q),
        .done  (gcd_done),
        .gcd   (gcd_val)
    );

    // One modular-accumulate step of r = e*d mod phi; the sum needs a carry bit.
    assign acc_sum_c  = {1'b0, r_q} + {1'b0, e_q};
    assign acc_wrap_c = (acc_sum_c >= {1'b0, phi_q}) ? DW'(acc_sum_c - {1'b0, phi_q})
                                                     : DW'(acc_sum_c);
    assign running_c  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);

    // State, working and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            p_q       <= '0;
            q_q       <= '0;
            n_q       <= '0;
            phi_q     <= '0;
            cand_q    <= '0;
            e_q       <= '0;
            dexp_q    <= '0;
            r_q       <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            n_out_q   <= '0;
            phi_out_q <= '0;
            e_out_q   <= '0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            n_q       <= n_d;
            phi_q     <= phi_d;
            cand_q    <= cand_d;
            e_q       <= e_d;
            dexp_q    <= dexp_d;
            r_q       <= r_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            n_out_q   <= n_out_d;
            phi_out_q <= phi_out_d;
            e_out_q   <= e_out_d;
            d_out_q   <= d_out_d;
        end
    end

    // Next-state and datapath; timeout then abort override the per-state decision.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        q_d         = q_q;
        n_d         = n_q;
        phi_d       = phi_q;
        cand_d      = cand_q;
        e_d         = e_q;
        dexp_d      = dexp_q;
        r_d         = r_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        n_out_d     = n_out_q;
        phi_out_d   = phi_out_q;
        e_out_d     = e_out_q;
        d_out_d     = d_out_q;
        gcd_start_c = 1'b0;
        gcd_clr_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d       = p_in;
                    q_d       = q_in;
                    tmo_d     = '0;
                    busy_d    = 1'b1;
                    n_out_d   = '0;
                    phi_out_d = '0;
                    e_out_d   = '0;
                    d_out_d   = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = ((p_q < W'(2)) || (q_q < W'(2))) ? ERR : CALC;
            end
            CALC: begin
                n_d     = DW'(p_q) * DW'(q_q);
                phi_d   = DW'(p_q - W'(1)) * DW'(q_q - W'(1));
                state_d = E_INIT;
            end
            E_INIT: begin
                cand_d = DW'(2);
                if (phi_q <= DW'(2)) begin
                    state_d = ERR;
                end else begin
                    gcd_start_c = 1'b1;
                    state_d     = GCD;
                end
            end
            GCD: begin
                if (gcd_done) begin
                    state_d = E_CHK;
                end
            end
            E_CHK: begin
                if (gcd_val == DW'(1)) begin
                    e_d     = cand_q;
                    state_d = D_INIT;
                end else begin
                    cand_d = cand_q + DW'(1);
                    if (cand_d == phi_q) begin
                        state_d = ERR;
                    end else begin
                        gcd_start_c = 1'b1;
                        state_d     = GCD;
                    end
                end
            end
            D_INIT: begin
                dexp_d  = DW'(1);
                r_d     = e_q;
                state_d = D_STEP;
            end
            D_STEP: begin
                if (r_q == DW'(1)) begin
                    state_d = DONE;
                end else begin
                    dexp_d = dexp_q + DW'(1);
                    r_d    = acc_wrap_c;
                    if (dexp_d == phi_q) begin
                        state_d = ERR;
                    end
                end
            end
            DONE: begin
                n_out_d   = n_q;
                phi_out_d = phi_q;
                e_out_d   = e_q;
                d_out_d   = dexp_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            ERR: begin
                n_out_d   = '0;
                phi_out_d = '0;
                e_out_d   = '0;
                d_out_d   = '0;
                err_d     = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (running_c) begin
            if (tmo_q >= TW'(TIMEOUT)) begin
                state_d   = ERR;
                gcd_clr_c = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (abort) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
            n_out_d   = '0;
            phi_out_d = '0;
            e_out_d   = '0;
            d_out_d   = '0;
            gcd_clr_c = 1'b1;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign n_out   = n_out_q;
    assign phi_out = phi_out_q;
    assign e_out   = e_out_q;
    assign d_out   = d_out_q;

endmodule

// File: tb/tb_rsa_key_sequencer.sv
// Self-checking bench for rsa_key_sequencer against an arithmetic key-set model.
module tb_rsa_key_sequencer;
    import rsa_ctrl_pkg::*;

    localparam int LIMIT = int'(RSA_TIMEOUT) + 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] p_in  = '0;
    logic [3:0] q_in  = '0;
    logic       busy, done, err;
    logic [7:0] n_out, phi_out, e_out, d_out;

    int checks   = 0;
    int failures = 0;

    rsa_key_sequencer #(.W(RSA_W), .TIMEOUT(RSA_TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .p_in    (p_in),
        .q_in    (q_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .n_out   (n_out),
        .phi_out (phi_out),
        .e_out   (e_out),
        .d_out   (d_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gcd_f(input int a_i, input int b_i);
        int a = a_i;
        int b = b_i;
        while (b != 0) begin
            int t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Key set from the definitions: smallest coprime e > 1, smallest inverse d.
    function automatic void model(input int p, input int q, output bit ok,
                                  output int n, output int phi, output int e, output int d);
        int ph;
        ok = 1'b0; n = 0; phi = 0; e = 0; d = 0;
        if (p < 2 || q < 2) return;
        ph = (p - 1) * (q - 1);
        if (ph <= 2) return;
        for (int c = 2; c < ph; c++) begin
            if (gcd_f(c, ph) == 1) begin e = c; break; end
        end
        if (e == 0) return;
        for (int k = 1; k < ph; k++) begin
            if ((e * k) % ph == 1) begin d = k; break; end
        end
        if (d == 0) begin e = 0; return; end
        ok = 1'b1; n = p * q; phi = ph;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"},  32'(err),  32'd0);
        chk({tag, "_n"},    32'(n_out), 32'd0);
        chk({tag, "_phi"},  32'(phi_out), 32'd0);
        chk({tag, "_e"},    32'(e_out), 32'd0);
        chk({tag, "_d"},    32'(d_out), 32'd0);
    endtask

    task automatic launch(input int p, input int q, input string tag);
        @(negedge clk);
        p_in  = 4'(p);
        q_in  = 4'(q);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    endtask

    task automatic await_pulse(input string tag, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_pulse_within_bound"}, 32'(got), 32'd1);
    endtask

    task automatic check_outcome(input int p, input int q, input string tag, input int lat);
        bit ok;
        int n, phi, e, d;
        model(p, q, ok, n, phi, e, d);
        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_err"},  32'(err),  32'(!ok));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_n"},    32'(n_out), 32'(n));
        chk({tag, "_phi"},  32'(phi_out), 32'(phi));
        chk({tag, "_e"},    32'(e_out), 32'(e));
        chk({tag, "_d"},    32'(d_out), 32'(d));
        if (ok) chk({tag, "_latency_lt_timeout"}, 32'(lat < int'(RSA_TIMEOUT)), 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_err_one_cycle"},  32'(err),  32'd0);
        chk({tag, "_n_hold"},         32'(n_out), 32'(n));
        chk({tag, "_d_hold"},         32'(d_out), 32'(d));
    endtask

    task automatic run_key(input int p, input int q, input string tag, output int lat);
        launch(p, q, tag);
        await_pulse(tag, lat);
        check_outcome(p, q, tag, lat);
    endtask

    initial begin
        int lat;
        bit pulse_seen;

        // Reset state
        #3;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("post_reset");

        // Directed key sets
        run_key(3, 11, "p3q11", lat);
        chk("p3q11_n_const", 32'(n_out), 32'd33);
        chk("p3q11_e_const", 32'(e_out), 32'd3);
        chk("p3q11_d_const", 32'(d_out), 32'd7);
        run_key(5, 7, "p5q7", lat);
        chk("p5q7_phi_const", 32'(phi_out), 32'd24);
        chk("p5q7_e_const", 32'(e_out), 32'd5);
        chk("p5q7_d_const", 32'(d_out), 32'd5);
        run_key(13, 11, "p13q11", lat);
        chk("p13q11_n_const", 32'(n_out), 32'd143);
        chk("p13q11_phi_const", 32'(phi_out), 32'd120);
        chk("p13q11_e_const", 32'(e_out), 32'd7);
        chk("p13q11_d_const", 32'(d_out), 32'd103);

        // Error cases
        run_key(1, 7, "p1q7", lat);
        chk("p1q7_err_latency", 32'(lat), 32'd2);
        run_key(2, 3, "p2q3", lat);
        chk("p2q3_err_flag", 32'(err), 32'd0);

        // Abort mid-GCD, then restart
        launch(13, 11, "abort_run");
        repeat (12) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_zero("abort");
        pulse_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || err === 1'b1 || busy === 1'b1) pulse_seen = 1'b1;
        end
        chk("abort_quiet", 32'(pulse_seen), 32'd0);
        run_key(13, 11, "after_abort", lat);

        // start while busy is ignored
        launch(5, 7, "restart_busy");
        repeat (4) @(negedge clk);
        p_in  = 4'd3;
        q_in  = 4'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_pulse("restart_busy", lat);
        check_outcome(5, 7, "restart_busy", lat);

        // Async reset while results are held
        run_key(3, 11, "pre_reset", lat);
        #2 reset = 1'b0;
        #1 check_zero("async_reset_hold");
        @(negedge clk);
        reset = 1'b1;

        // Async reset mid-run, then a normal run
        launch(13, 11, "reset_run");
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("async_reset_mid");
        @(negedge clk);
        reset = 1'b1;
        run_key(5, 7, "after_reset", lat);

        // Randomized operands, including degenerate ones
        for (int i = 0; i < 16; i++) begin
            int rp = int'($urandom_range(0, 15));
            int rq = int'($urandom_range(0, 15));
            run_key(rp, rq, $sformatf("rand%0d_p%0d_q%0d", i, rp, rq), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
